// File: rtl/ddr2_sdram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_sdram_arb_pkg
// Shared types for the DDR2 local-port arbiter:
//   arb_state_e : arbiter FSM state (IDLE, WR_BURST)
//   arb_tag_t   : one outstanding-read record {port index, remaining beats}
//   clog2       : constant-friendly ceiling log2
// The tag fields are sized for the largest supported configuration
// (8 ports, SIZE_BITS up to 8) so one packed type serves every instance.
// ----------------------------------------------------------------------------
package ddr2_sdram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } arb_state_e;

    localparam int TAG_PORT_BITS = 3;
    localparam int TAG_CNT_BITS  = 8;

    typedef struct packed {
        logic [TAG_PORT_BITS-1:0] port;
        logic [TAG_CNT_BITS-1:0]  remaining;
    } arb_tag_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr2_sdram_arb_tag_fifo.sv
// ----------------------------------------------------------------------------
// ddr2_sdram_arb_tag_fifo
// Synchronous FIFO of outstanding-read tags (DEPTH entries, power of 2, >= 2).
// The head entry's remaining-beat count can be decremented in place; the
// owner pops the entry on its last beat. Push and pop in the same cycle are
// both honoured, including when the FIFO is full.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   push, push_tag   : write a new tag
//   dec_head         : one read beat consumed from the head entry
//   pop              : retire the head entry
//   head             : current head tag
//   full, empty      : occupancy flags
// ----------------------------------------------------------------------------
module ddr2_sdram_arb_tag_fifo
    import ddr2_sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  arb_tag_t push_tag,
    input  logic     dec_head,
    input  logic     pop,
    output arb_tag_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_BITS = clog2(DEPTH);

    arb_tag_t            mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [PTR_BITS:0]   count_q;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_BITS+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            if (do_push && !do_pop)      count_q <= count_q + (PTR_BITS+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (PTR_BITS+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    // A push never lands on the head slot while it is being decremented
    // (that needs empty, which blocks the decrement, or full, which forces a pop).
    always_ff @(posedge clk) begin
        if (dec_head && !do_pop && !empty)
            mem_q[rd_ptr_q].remaining <= mem_q[rd_ptr_q].remaining - TAG_CNT_BITS'(1);
        if (do_push)
            mem_q[wr_ptr_q] <= push_tag;
    end

endmodule

// File: rtl/ddr2_sdram_local_port_arbiter.sv
// ----------------------------------------------------------------------------
// ddr2_sdram_local_port_arbiter
// Round-robin front end for the DDR2 controller's native local interface.
// A granted write burst keeps the grant until all its beats are accepted;
// issued reads are tagged so returning beats are steered to their port.
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   port_read_req/write_req/burstbegin, port_addr, port_size, port_wdata,
//   port_be                          : flattened per-port requests
//   port_ready                       : per-port accept strobe
//   port_rdata, port_rdata_valid     : read data broadcast + one-hot owner
//   local_*                          : controller side
//   rd_underflow                     : sticky, read beat with nothing pending
//   dbg_state                        : arbiter FSM state for observation
// Handshake: a port's command/beat is transferred in any cycle where its
// port_ready bit is 1 (this equals local_ready while the port owns the
// local interface); all request and data signals are sampled in that cycle.
// ----------------------------------------------------------------------------
module ddr2_sdram_local_port_arbiter
    import ddr2_sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DATA_BITS = 64,
    parameter int ROW_BITS  = 13,
    parameter int BANK_BITS = 2,
    parameter int COL_BITS  = 10,
    parameter int SIZE_BITS = 2,
    parameter int TAG_DEPTH = 8,
    localparam int AW  = ROW_BITS + BANK_BITS + COL_BITS - 1,
    localparam int BEW = DATA_BITS / 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PORTS-1:0]           port_read_req,
    input  logic [NUM_PORTS-1:0]           port_write_req,
    input  logic [NUM_PORTS-1:0]           port_burstbegin,
    input  logic [NUM_PORTS*AW-1:0]        port_addr,
    input  logic [NUM_PORTS*SIZE_BITS-1:0] port_size,
    input  logic [NUM_PORTS*DATA_BITS-1:0] port_wdata,
    input  logic [NUM_PORTS*BEW-1:0]       port_be,
    output logic [NUM_PORTS-1:0]           port_ready,
    output logic [DATA_BITS-1:0]           port_rdata,
    output logic [NUM_PORTS-1:0]           port_rdata_valid,
    input  logic                           local_ready,
    input  logic                           local_init_done,
    input  logic                           local_rdata_valid,
    input  logic [DATA_BITS-1:0]           local_rdata,
    output logic                           local_read_req,
    output logic                           local_write_req,
    output logic                           local_burstbegin,
    output logic [ROW_BITS-1:0]            local_row_addr,
    output logic [BANK_BITS-1:0]           local_bank_addr,
    output logic [COL_BITS-2:0]            local_col_addr,
    output logic [SIZE_BITS-1:0]           local_size,
    output logic [DATA_BITS-1:0]           local_wdata,
    output logic [BEW-1:0]                 local_be,
    output logic                           rd_underflow,
    output arb_state_e                     dbg_state
);

    localparam int PW = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

    arb_state_e           state_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        lat_q;
    logic [SIZE_BITS-1:0] beats_q;
    logic                 uf_q;

    logic [NUM_PORTS-1:0] eligible;
    logic                 gnt_valid;
    logic [PW-1:0]        gnt_idx;
    logic [PW-1:0]        sel_idx;
    logic                 gnt_is_wr;
    logic                 in_idle;
    logic                 path_active;
    logic                 beat_ok;
    logic [AW-1:0]        sel_addr;
    logic [SIZE_BITS-1:0] sel_size;
    logic [SIZE_BITS-1:0] eff_size;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_dec;
    logic                 read_room;
    arb_tag_t             head_tag;
    arb_tag_t             push_tag;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (int'(p) == NUM_PORTS - 1) ? PW'(0) : p + PW'(1);
    endfunction

    // A read may go out when a slot is free now or the head retires this cycle.
    assign read_room = ~fifo_full | fifo_pop;
    assign eligible  = port_burstbegin &
                       (port_write_req | (port_read_req & {NUM_PORTS{read_room}}));

    // First eligible port at or after the priority pointer, wrapping.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!gnt_valid && eligible[(int'(ptr_q) + k) % NUM_PORTS]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'((int'(ptr_q) + k) % NUM_PORTS);
            end
        end
    end

    assign in_idle     = (state_q == IDLE);
    assign sel_idx     = in_idle ? gnt_idx : lat_q;
    assign gnt_is_wr   = port_write_req[gnt_idx];
    assign beat_ok     = local_init_done & local_ready;
    // reset_n gates the combinational outputs so they are quiet during reset.
    assign path_active = reset_n & local_init_done & (in_idle ? gnt_valid : 1'b1);

    assign local_read_req   = path_active & in_idle & ~gnt_is_wr;
    assign local_write_req  = path_active & (in_idle ? gnt_is_wr : port_write_req[lat_q]);
    assign local_burstbegin = path_active & in_idle;
    assign port_ready       = path_active ? (NUM_PORTS'(local_ready) << sel_idx) : '0;

    assign sel_addr        = port_addr[int'(sel_idx)*AW +: AW];
    assign local_row_addr  = sel_addr[AW-1 -: ROW_BITS];
    assign local_bank_addr = sel_addr[COL_BITS-1 +: BANK_BITS];
    assign local_col_addr  = sel_addr[COL_BITS-2:0];
    assign sel_size        = port_size[int'(sel_idx)*SIZE_BITS +: SIZE_BITS];
    assign eff_size        = (sel_size == '0) ? SIZE_BITS'(1) : sel_size;
    assign local_size      = eff_size;
    assign local_wdata     = port_wdata[int'(sel_idx)*DATA_BITS +: DATA_BITS];
    assign local_be        = port_be[int'(sel_idx)*BEW +: BEW];

    // Read return steering.
    assign fifo_dec         = local_rdata_valid & ~fifo_empty;
    assign fifo_pop         = fifo_dec & (head_tag.remaining <= TAG_CNT_BITS'(1));
    assign fifo_push        = local_read_req & local_ready;
    assign push_tag.port    = TAG_PORT_BITS'(gnt_idx);
    assign push_tag.remaining = TAG_CNT_BITS'(eff_size);
    assign port_rdata       = local_rdata;
    assign port_rdata_valid = (reset_n & fifo_dec) ? (NUM_PORTS'(1) << head_tag.port) : '0;
    assign rd_underflow     = uf_q;
    assign dbg_state        = state_q;

    ddr2_sdram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_tag (push_tag),
        .dec_head (fifo_dec),
        .pop      (fifo_pop),
        .head     (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lat_q   <= '0;
            beats_q <= '0;
            uf_q    <= 1'b0;
        end else begin
            if (local_rdata_valid && fifo_empty) uf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (gnt_valid && beat_ok) begin
                        if (gnt_is_wr && eff_size != SIZE_BITS'(1)) begin
                            state_q <= WR_BURST;
                            lat_q   <= gnt_idx;
                            beats_q <= eff_size - SIZE_BITS'(1);
                        end else begin
                            ptr_q <= next_port(gnt_idx);
                        end
                    end
                end
                WR_BURST: begin
                    if (beat_ok && port_write_req[lat_q]) begin
                        beats_q <= beats_q - SIZE_BITS'(1);
                        if (beats_q == SIZE_BITS'(1)) begin
                            state_q <= IDLE;
                            ptr_q   <= next_port(lat_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_sdram_local_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr2_sdram_local_port_arbiter
// Directed bench for the DDR2 local-port arbiter (2 ports, 8-deep tag FIFO).
// A queue-based model of the arbitration and read-return rules is compared
// against the DUT every falling edge; directed literal checks pin key events.
// ----------------------------------------------------------------------------
module tb_ddr2_sdram_local_port_arbiter;
    import ddr2_sdram_arb_pkg::*;

    localparam int N   = 2;
    localparam int DW  = 64;
    localparam int RB  = 13;
    localparam int BB  = 2;
    localparam int CB  = 10;
    localparam int SB  = 2;
    localparam int TD  = 8;
    localparam int AW  = RB + BB + CB - 1;
    localparam int BEW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      p_rd    = '0;
    logic [N-1:0]      p_wr    = '0;
    logic [N-1:0]      p_bb    = '0;
    logic [N*AW-1:0]   p_addr  = '0;
    logic [N*SB-1:0]   p_size  = '0;
    logic [N*DW-1:0]   p_wdata = '0;
    logic [N*BEW-1:0]  p_be    = '0;
    logic              lr      = 1'b0;
    logic              init    = 1'b0;
    logic              lrv     = 1'b0;
    logic [DW-1:0]     lrdata  = '0;

    logic [N-1:0]      port_ready;
    logic [DW-1:0]     port_rdata;
    logic [N-1:0]      port_rdata_valid;
    logic              local_read_req;
    logic              local_write_req;
    logic              local_burstbegin;
    logic [RB-1:0]     local_row_addr;
    logic [BB-1:0]     local_bank_addr;
    logic [CB-2:0]     local_col_addr;
    logic [SB-1:0]     local_size;
    logic [DW-1:0]     local_wdata;
    logic [BEW-1:0]    local_be;
    logic              rd_underflow;
    arb_state_e        dbg_state;

    ddr2_sdram_local_port_arbiter #(
        .NUM_PORTS (N), .DATA_BITS (DW), .ROW_BITS (RB), .BANK_BITS (BB),
        .COL_BITS (CB), .SIZE_BITS (SB), .TAG_DEPTH (TD)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .port_read_req     (p_rd),
        .port_write_req    (p_wr),
        .port_burstbegin   (p_bb),
        .port_addr         (p_addr),
        .port_size         (p_size),
        .port_wdata        (p_wdata),
        .port_be           (p_be),
        .port_ready        (port_ready),
        .port_rdata        (port_rdata),
        .port_rdata_valid  (port_rdata_valid),
        .local_ready       (lr),
        .local_init_done   (init),
        .local_rdata_valid (lrv),
        .local_rdata       (lrdata),
        .local_read_req    (local_read_req),
        .local_write_req   (local_write_req),
        .local_burstbegin  (local_burstbegin),
        .local_row_addr    (local_row_addr),
        .local_bank_addr   (local_bank_addr),
        .local_col_addr    (local_col_addr),
        .local_size        (local_size),
        .local_wdata       (local_wdata),
        .local_be          (local_be),
        .rd_underflow      (rd_underflow),
        .dbg_state         (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_log(input int q[$]);
        logic [63:0] v;
        v = '0;
        foreach (q[i]) v = (v << 4) | 64'(q[i]);
        return v;
    endfunction

    // Model state: outstanding reads as {port, beats}, priority port, burst owner.
    typedef struct {
        int port;
        int cnt;
    } rd_tag_t;

    rd_tag_t out_q[$];
    int      m_ptr   = 0;
    bit      m_burst = 1'b0;
    int      m_owner = 0;
    int      m_left  = 0;
    bit      m_uf    = 1'b0;

    // Observation logs taken from the DUT's handshakes.
    int cyc = 0;
    int rd_log[$];
    int rd_cyc_log[$];
    int rv_log[$];
    int wbeats[N];
    int last_wb_cyc = 0;

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rv;
        logic         e_rreq;
        logic         e_wreq;
        logic         e_bb;
        bit           pop_now;
        int           w;
        int           sel;
        int           es;
        cyc++;
        chk("rdata", port_rdata, lrdata);
        if (!reset_n) begin
            out_q.delete();
            m_ptr   = 0;
            m_burst = 1'b0;
            m_uf    = 1'b0;
            chk("reset_outs", {port_ready, port_rdata_valid, local_read_req,
                               local_write_req, local_burstbegin, rd_underflow}, '0);
        end else begin
            e_ready = '0;
            e_rv    = '0;
            e_rreq  = 1'b0;
            e_wreq  = 1'b0;
            e_bb    = 1'b0;
            w       = -1;
            sel     = -1;
            es      = 1;
            pop_now = lrv && out_q.size() > 0 && out_q[0].cnt == 1;
            if (lrv && out_q.size() > 0) e_rv = N'(1) << out_q[0].port;
            if (init) begin
                if (m_burst) begin
                    sel           = m_owner;
                    e_ready[sel]  = lr;
                    e_wreq        = p_wr[sel];
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int p;
                        p = (m_ptr + k) % N;
                        if (w < 0 && p_bb[p] &&
                            (p_wr[p] || (p_rd[p] && (out_q.size() < TD || pop_now))))
                            w = p;
                    end
                    if (w >= 0) begin
                        sel        = w;
                        e_ready[w] = lr;
                        e_wreq     = p_wr[w];
                        e_rreq     = !p_wr[w];
                        e_bb       = 1'b1;
                    end
                end
            end
            chk("ctrl", {port_ready, local_read_req, local_write_req, local_burstbegin,
                         port_rdata_valid, rd_underflow, dbg_state == WR_BURST},
                        {e_ready, e_rreq, e_wreq, e_bb, e_rv, m_uf, m_burst});
            if (sel >= 0) begin
                es = (p_size[sel*SB +: SB] == '0) ? 1 : int'(p_size[sel*SB +: SB]);
                chk("addr",  {local_row_addr, local_bank_addr, local_col_addr}, p_addr[sel*AW +: AW]);
                chk("size",  local_size, es);
                chk("wdata", local_wdata, p_wdata[sel*DW +: DW]);
                chk("be",    local_be, p_be[sel*BEW +: BEW]);
            end

            // logs of what the DUT actually did this cycle
            if (local_read_req && lr) begin
                for (int p = 0; p < N; p++) if (port_ready[p]) rd_log.push_back(p);
                rd_cyc_log.push_back(cyc);
            end
            if (local_write_req && lr) begin
                for (int p = 0; p < N; p++) if (port_ready[p]) begin
                    wbeats[p]++;
                    last_wb_cyc = cyc;
                end
            end
            if (port_rdata_valid != '0) rv_log.push_back(int'(port_rdata_valid));

            // advance the model to the next cycle
            if (lrv) begin
                if (out_q.size() > 0) begin
                    out_q[0].cnt--;
                    if (out_q[0].cnt == 0) void'(out_q.pop_front());
                end else begin
                    m_uf = 1'b1;
                end
            end
            if (init && lr) begin
                if (m_burst) begin
                    if (p_wr[m_owner]) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_burst = 1'b0;
                            m_ptr   = (m_owner + 1) % N;
                        end
                    end
                end else if (w >= 0) begin
                    if (p_wr[w]) begin
                        if (es > 1) begin
                            m_burst = 1'b1;
                            m_owner = w;
                            m_left  = es - 1;
                        end else begin
                            m_ptr = (w + 1) % N;
                        end
                    end else begin
                        out_q.push_back('{w, es});
                        m_ptr = (w + 1) % N;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rnd();
        for (int i = 0; i < N; i++) begin
            p_addr[i*AW +: AW]    = AW'($urandom());
            p_wdata[i*DW +: DW]   = {$urandom(), $urandom()};
            p_be[i*BEW +: BEW]    = BEW'($urandom());
        end
        lrdata = {$urandom(), $urandom()};
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr, input bit bb, input int sz);
        p_rd[p]            = rd;
        p_wr[p]            = wr;
        p_bb[p]            = bb;
        p_size[p*SB +: SB] = SB'(sz);
    endtask

    task automatic step();
        rnd();
        @(posedge clk);
        #1;
    endtask

    // Settle to just after the falling edge of the current cycle.
    task automatic look();
        rnd();
        @(negedge clk);
        #2;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // init gating
        set_port(0, 1, 0, 1, 1);
        set_port(1, 1, 0, 1, 1);
        lr = 1'b1;
        look();
        chk("init_gate_ready", port_ready, 2'b00);
        chk("init_gate_req", {local_read_req, local_write_req}, 2'b00);
        end_cycle();
        step();

        // init raised: port 0 first, then round robin 0,1,0,1
        init = 1'b1;
        rd_log.delete();
        look();
        chk("first_grant", port_ready, 2'b01);
        end_cycle();
        repeat (3) step();
        set_port(0, 0, 0, 0, 1);
        set_port(1, 0, 0, 0, 1);
        chk("rr_count", rd_log.size(), 4);
        chk("rr_seq", pack_log(rd_log), 64'h0101);

        rv_log.delete();
        lrv = 1'b1;
        repeat (4) step();
        lrv = 1'b0;
        chk("rv_seq", pack_log(rv_log), 64'h1212);

        // write burst lock: port 1 size 3, port 0 read waits
        rd_log.delete();
        rd_cyc_log.delete();
        wbeats[0] = 0;
        wbeats[1] = 0;
        set_port(1, 0, 1, 1, 3);
        step();
        set_port(1, 0, 1, 0, 3);
        set_port(0, 1, 0, 1, 1);
        step();
        lr = 1'b0;
        repeat (2) step();
        lr = 1'b1;
        step();
        set_port(1, 0, 0, 0, 1);
        step();
        set_port(0, 0, 0, 0, 1);
        chk("burst_beats_p1", wbeats[1], 3);
        chk("burst_beats_p0", wbeats[0], 0);
        chk("burst_then_read", pack_log(rd_log) | (64'(rd_log.size()) << 32), 64'h1_0000_0000);
        if (rd_cyc_log.size() > 0) chk("read_after_burst", rd_cyc_log[0] > last_wb_cyc, 1'b1);
        else chk("read_after_burst", 0, 1);

        // fill tag FIFO (1 already outstanding)
        set_port(0, 1, 0, 1, 1);
        repeat (7) step();
        set_port(1, 0, 1, 1, 1);
        look();
        chk("full_stall_ready", port_ready, 2'b10);
        chk("full_stall_req", {local_read_req, local_write_req}, 2'b01);
        end_cycle();
        set_port(1, 0, 0, 0, 1);
        lrv = 1'b1;
        look();
        chk("pop_push_ready", port_ready, 2'b01);
        chk("pop_push_rv", port_rdata_valid, 2'b01);
        end_cycle();
        set_port(0, 0, 0, 0, 1);
        rv_log.delete();
        repeat (8) step();
        lrv = 1'b0;
        chk("drain_seq", pack_log(rv_log), 64'h1111_1111);

        // multi-beat read, then a spurious beat
        set_port(1, 1, 0, 1, 3);
        step();
        set_port(1, 0, 0, 0, 1);
        rv_log.delete();
        lrv = 1'b1;
        repeat (3) step();
        chk("multi_beat_seq", pack_log(rv_log), 64'h222);
        look();
        chk("spurious_rv", port_rdata_valid, 2'b00);
        end_cycle();
        lrv = 1'b0;
        look();
        chk("underflow_set", rd_underflow, 1'b1);
        end_cycle();
        repeat (3) step();
        chk("underflow_held", rd_underflow, 1'b1);

        // reset mid-burst
        set_port(0, 1, 0, 1, 1);
        step();
        set_port(0, 0, 0, 0, 1);
        set_port(1, 0, 1, 1, 3);
        step();
        set_port(1, 0, 1, 0, 3);
        rnd();
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", {port_ready, port_rdata_valid, local_read_req, local_write_req,
                                 local_burstbegin, rd_underflow, dbg_state == WR_BURST}, '0);
        set_port(1, 0, 0, 0, 1);
        lr = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        end_cycle();
        set_port(0, 1, 0, 1, 1);
        set_port(1, 1, 0, 1, 1);
        lr = 1'b1;
        look();
        chk("post_reset_grant", port_ready, 2'b01);
        end_cycle();
        step();
        set_port(0, 0, 0, 0, 1);
        set_port(1, 0, 0, 0, 1);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
